hcsr04_emulador: RTL and testbench
==================================

# hcsr04_emulador

Emulates the responder side of an HC-SR04 ultrasonic sensor: it accepts the trigger pulse from a measuring interface and returns an echo pulse whose width encodes a programmed distance in centimetres. It sits on the FPGA opposite the sensor interface, either wired in loopback or driving a GPIO header. Its purpose is closed-loop bench and board testing of the measurement path without a physical sensor.

## Interface
- `TRIG_MIN_CYCLES`, 500 — minimum synchronized trigger high width accepted (10 µs @ 50 MHz).
- `DELAY_CYCLES`, 10000 — trigger-fall to echo-rise delay; emulates the 8-pulse burst (200 µs).
- `CM_CYCLES`, 2941 — echo high cycles per cm (58.82 µs/cm).
- `MAX_CM`, 400 — largest valid distance.
- `HOLDOFF_CYCLES`, 500000 — recovery time after echo falls (10 ms).
- `TIMEOUT_CYCLES`, 1900000 — out-of-range echo width (38 ms); used only with the macro.

Ports:
- `clock` in 1 — system clock.
- `reset` in 1 — synchronous, active-low; 0 resets on the next rising edge.
- `trigger` in 1 — asynchronous trigger from the measuring side.
- `distancia` in 9 — emulated distance, unsigned binary cm.
- `echo` out 1 — emulated echo pulse, registered.
- `ocupado` out 1 — high while a measurement cycle is in progress.
- `db_estado` out 4 — current state code.

## Operation
- `trigger` passes through a 2-FF synchronizer; all timing is referenced to the synchronized signal `trig_s`. Edges are detected against one further register.
- States and codes:
  - REPOUSO = 0
  - MEDE_TRIGGER = 1
  - RAJADA = 2
  - ECO = 3
  - FIM = 4
  - Unused codes return to REPOUSO.
- **REPOUSO:** on a rising edge of `trig_s`, go to MEDE_TRIGGER and clear the width counter. A `trig_s` level that is already high, with no edge, is ignored.
- **MEDE_TRIGGER:** count high cycles, saturating at `TRIG_MIN_CYCLES`. On the falling edge:
  - If count ≥ `TRIG_MIN_CYCLES`: latch `distancia` and go to RAJADA.
  - Otherwise: return to REPOUSO (pulse rejected).
- **RAJADA:** wait `DELAY_CYCLES`, then go to ECO.
- **ECO:** hold `echo` = 1 for exactly W cycles, then go to FIM.
  - In range (2 ≤ latched d ≤ `MAX_CM`): W = d × `CM_CYCLES`.
  - Out of range: see Configuration.
- **FIM:** hold `echo` = 0 for `HOLDOFF_CYCLES`, then go to REPOUSO.
- Trigger activity in RAJADA, ECO or FIM is ignored. If `trigger` is still high on return to REPOUSO, a new low→high edge is required before acceptance.
- Changes to `distancia` after the latch do not affect the cycle in progress.
- Use one shared down-counter, at least 24 bits wide. Every parameter product must fit in it; W is computed at the latch cycle as a registered product.
- `ocupado` = 1 in RAJADA, ECO and FIM.
- Reset (`reset` = 0) takes effect at the next edge, including mid-echo: state REPOUSO, `echo` = 0, `ocupado` = 0, `db_estado` = 0, counters and latch cleared, synchronizer flops cleared.

## Timing
- Let T be the cycle in which the falling edge of `trig_s` is detected with a valid width. Then:
  - `ocupado` rises at T+1.
  - `echo` rises at T+1+`DELAY_CYCLES`.
  - `echo` stays high for exactly W cycles.
  - `ocupado` falls `HOLDOFF_CYCLES` cycles after `echo` falls.
- Raw `trigger` to `trig_s` latency: 2 cycles, plus 1 cycle for edge detection.
- Accepted high width is measured on `trig_s` and is inclusive: exactly `TRIG_MIN_CYCLES` is accepted, one cycle fewer is rejected.
- The earliest re-trigger is a rising edge in the cycle after FIM exits.

## Configuration
- `HCSR04_EMU_TIMEOUT_EN`
  - Defined: out-of-range latched distance (d < 2 or d > `MAX_CM`) gives W = `TIMEOUT_CYCLES`, emulating the sensor's no-object timeout.
  - Undefined: out-of-range d is clamped. d < 2 is treated as 2, d > `MAX_CM` as `MAX_CM`. `TIMEOUT_CYCLES` is unused.

## Test plan
Bench parameters: `TRIG_MIN_CYCLES`=5, `DELAY_CYCLES`=20, `CM_CYCLES`=3, `MAX_CM`=400, `HOLDOFF_CYCLES`=10, `TIMEOUT_CYCLES`=1500.

1. `distancia`=100, 6-cycle trigger → `echo` rises 21 cycles after the detected fall and stays high exactly 300 cycles. `ocupado` falls 10 cycles after `echo` falls. `db_estado` sequence is 0,1,2,3,4,0.
2. Trigger widths of 4 and 5 cycles → the 4-cycle pulse gives no `echo` and a return to state 0; the 5-cycle pulse is accepted.
3. `distancia` changed 100→7 during ECO, plus a second valid trigger during RAJADA → width stays 300, and no second echo occurs.
4. `distancia`=450:
   - With the macro: echo width 1500.
   - Without it: echo width 1200.
   - Repeat with `distancia`=0: 1500 with the macro, 6 without.
5. `reset`=0 for one cycle midway through ECO → `echo`, `ocupado` and `db_estado` read 0 on the next edge. A fresh valid trigger then gives a correct full cycle.
6. `trigger` held high from FIM through 50 cycles into REPOUSO → no acceptance until it falls and rises again.

Source files
------------

// File: rtl/hcsr04_emulador_if.sv
// Signal bundle between an HC-SR04 measuring interface (master) and the
// sensor emulator (slave): trigger/distance in, echo/status out.
interface hcsr04_emulador_if;
    logic       trigger;
    logic [8:0] distancia;
    logic       echo;
    logic       ocupado;
    logic [3:0] db_estado;

    modport master (
        output trigger,
        output distancia,
        input  echo,
        input  ocupado,
        input  db_estado
    );

    modport slave (
        input  trigger,
        input  distancia,
        output echo,
        output ocupado,
        output db_estado
    );
endinterface

// File: rtl/hcsr04_emulador.sv
// HC-SR04 responder emulator: accepts a trigger pulse and answers with an echo
// pulse whose width encodes the programmed distance in centimetres.
// Optional feature macro: HCSR04_EMU_TIMEOUT_EN (out-of-range distance gives a
// TIMEOUT_CYCLES echo instead of clamping to the valid range).
module hcsr04_emulador #(
    parameter int unsigned TRIG_MIN_CYCLES = 500,
    parameter int unsigned DELAY_CYCLES    = 10000,
    parameter int unsigned CM_CYCLES       = 2941,
    parameter int unsigned MAX_CM          = 400,
    parameter int unsigned HOLDOFF_CYCLES  = 500000,
    parameter int unsigned TIMEOUT_CYCLES  = 1900000
) (
    input logic               clock,
    input logic               reset,
    hcsr04_emulador_if.slave  bus
);

    // Shared counter is sized for the largest interval any state can load.
    localparam longint unsigned PROD_MAX  = 64'(MAX_CM) * 64'(CM_CYCLES);
    localparam longint unsigned SPAN_A    = (PROD_MAX > 64'(TIMEOUT_CYCLES)) ? PROD_MAX : 64'(TIMEOUT_CYCLES);
    localparam longint unsigned SPAN_B    = (SPAN_A > 64'(DELAY_CYCLES)) ? SPAN_A : 64'(DELAY_CYCLES);
    localparam longint unsigned SPAN_C    = (SPAN_B > 64'(HOLDOFF_CYCLES)) ? SPAN_B : 64'(HOLDOFF_CYCLES);
    localparam longint unsigned SPAN_MAX  = (SPAN_C > 64'(TRIG_MIN_CYCLES)) ? SPAN_C : 64'(TRIG_MIN_CYCLES);
    localparam int unsigned     SPAN_BITS = 32'($clog2(SPAN_MAX + 64'd1));
    localparam int unsigned     CNT_W     = (SPAN_BITS > 32'd24) ? SPAN_BITS : 32'd24;

    typedef enum logic [3:0] {
        REPOUSO      = 4'd0,
        MEDE_TRIGGER = 4'd1,
        RAJADA       = 4'd2,
        ECO          = 4'd3,
        FIM          = 4'd4
    } state_t;

    logic             trig_m;
    logic             trig_s;
    logic             trig_d;
    logic             rise;
    logic             fall;
    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic [CNT_W-1:0] w_reg;
    logic [CNT_W-1:0] w_calc;
    logic             w_load;
    logic             echo_reg;
    logic             ocupado_reg;

    // Two-flop synchronizer plus one edge-detect stage on the raw trigger.
    always_ff @(posedge clock) begin
        if (!reset) begin
            trig_m <= 1'b0;
            trig_s <= 1'b0;
            trig_d <= 1'b0;
        end else begin
            trig_m <= bus.trigger;
            trig_s <= trig_m;
            trig_d <= trig_s;
        end
    end

    assign rise = trig_s & ~trig_d;
    assign fall = ~trig_s & trig_d;

`ifdef HCSR04_EMU_TIMEOUT_EN
    // Echo width: out-of-range distance emulates the sensor's no-object timeout.
    always_comb begin
        if ((bus.distancia < 9'd2) || (32'(bus.distancia) > MAX_CM)) begin
            w_calc = CNT_W'(TIMEOUT_CYCLES);
        end else begin
            w_calc = CNT_W'(bus.distancia) * CNT_W'(CM_CYCLES);
        end
    end
`else
    logic [8:0] d_eff;

    // Echo width: out-of-range distance is clamped into [2, MAX_CM].
    always_comb begin
        d_eff = bus.distancia;
        if (bus.distancia < 9'd2) begin
            d_eff = 9'd2;
        end else if (32'(bus.distancia) > MAX_CM) begin
            d_eff = 9'(MAX_CM);
        end
        w_calc = CNT_W'(d_eff) * CNT_W'(CM_CYCLES);
    end
`endif

    // Next-state and counter logic; the counter counts up while measuring the
    // trigger and down while timing the burst, echo and holdoff intervals.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        w_load     = 1'b0;
        case (state)
            REPOUSO: begin
                if (rise) begin
                    state_next = MEDE_TRIGGER;
                    cnt_next   = '0;
                end
            end
            MEDE_TRIGGER: begin
                // The rise cycle itself is one high cycle not seen by the counter.
                if (fall) begin
                    if (cnt >= CNT_W'(TRIG_MIN_CYCLES - 32'd1)) begin
                        state_next = RAJADA;
                        cnt_next   = CNT_W'(DELAY_CYCLES - 32'd1);
                        w_load     = 1'b1;
                    end else begin
                        state_next = REPOUSO;
                    end
                end else if (trig_s && (cnt < CNT_W'(TRIG_MIN_CYCLES))) begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            RAJADA: begin
                if (cnt == '0) begin
                    state_next = ECO;
                    cnt_next   = w_reg - CNT_W'(1);
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end
            ECO: begin
                if (cnt == '0) begin
                    state_next = FIM;
                    cnt_next   = CNT_W'(HOLDOFF_CYCLES - 32'd1);
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end
            FIM: begin
                if (cnt == '0) begin
                    state_next = REPOUSO;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end
            default: begin
                state_next = REPOUSO;
                cnt_next   = '0;
            end
        endcase
    end

    // State, counter, latched echo width and registered outputs.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state       <= REPOUSO;
            cnt         <= '0;
            w_reg       <= '0;
            echo_reg    <= 1'b0;
            ocupado_reg <= 1'b0;
        end else begin
            state       <= state_next;
            cnt         <= cnt_next;
            if (w_load) begin
                w_reg <= w_calc;
            end
            echo_reg    <= (state_next == ECO);
            ocupado_reg <= (state_next == RAJADA) || (state_next == ECO) || (state_next == FIM);
        end
    end

    assign bus.echo      = echo_reg;
    assign bus.ocupado   = ocupado_reg;
    assign bus.db_estado = state;

endmodule

// File: tb/tb_hcsr04_emulador.sv
// Scoreboard bench for hcsr04_emulador: stimulus pushes the expected state
// sequence and echo width per measurement; a negedge monitor times each cycle.
module tb_hcsr04_emulador;

    localparam int unsigned TRIG_MIN = 5;
    localparam int unsigned DELAY    = 20;
    localparam int unsigned CM       = 3;
    localparam int unsigned MAXCM    = 400;
    localparam int unsigned HOLD     = 10;
    localparam int unsigned TMO      = 1500;

`ifdef HCSR04_EMU_TIMEOUT_EN
    localparam int EXP_HI = 1500;
    localparam int EXP_LO = 1500;
`else
    localparam int EXP_HI = 1200;
    localparam int EXP_LO = 6;
`endif

    localparam logic [31:0] SEQ_FULL = 32'h0001_2340;
    localparam logic [31:0] SEQ_REJ  = 32'h0000_0010;

    typedef struct {
        logic [31:0] seq;
        int          width;
    } exp_t;

    logic clock;
    logic reset;
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];
    bit   mon_flush = 1'b0;

    hcsr04_emulador_if bus();

    hcsr04_emulador #(
        .TRIG_MIN_CYCLES (TRIG_MIN),
        .DELAY_CYCLES    (DELAY),
        .CM_CYCLES       (CM),
        .MAX_CM          (MAXCM),
        .HOLDOFF_CYCLES  (HOLD),
        .TIMEOUT_CYCLES  (TMO)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: tracks edges of echo/ocupado and the state trail, pops on return to idle.
    logic [3:0]  m_prev_st   = 4'd0;
    logic        m_prev_echo = 1'b0;
    logic        m_prev_oc   = 1'b0;
    logic [31:0] m_seq       = 32'd0;
    bit          m_echo_seen = 1'b0;
    int          t_det = 0, t_orise = 0, t_erise = 0, t_efall = 0, t_ofall = 0;
    exp_t        m_exp;

    initial begin
        forever begin
            @(negedge clock);
            if (bus.db_estado == 4'd1) t_det = cyc;
            if (bus.ocupado && !m_prev_oc) t_orise = cyc;
            if (!bus.ocupado && m_prev_oc) t_ofall = cyc;
            if (bus.echo && !m_prev_echo) begin
                t_erise     = cyc;
                m_echo_seen = 1'b1;
            end
            if (!bus.echo && m_prev_echo) t_efall = cyc;
            if (bus.db_estado != m_prev_st) begin
                m_seq = (m_seq << 4) | 32'(bus.db_estado);
                if (bus.db_estado == 4'd0) begin
                    if (mon_flush) begin
                        mon_flush = 1'b0;
                    end else begin
                        check("expected_pending", int'(sb.size() > 0), 1);
                        if (sb.size() > 0) begin
                            m_exp = sb.pop_front();
                            check("state_seq", int'(m_seq), int'(m_exp.seq));
                            if (m_exp.width != 0) begin
                                check("ocupado_rise_lat", t_orise - t_det, 1);
                                check("echo_rise_lat", t_erise - t_det, int'(DELAY) + 1);
                                check("echo_width", t_efall - t_erise, m_exp.width);
                                check("holdoff", t_ofall - t_efall, int'(HOLD));
                            end else begin
                                check("no_echo", int'(m_echo_seen), 0);
                            end
                        end
                    end
                    m_seq       = 32'd0;
                    m_echo_seen = 1'b0;
                end
            end
            m_prev_st   = bus.db_estado;
            m_prev_echo = bus.echo;
            m_prev_oc   = bus.ocupado;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic pulse(input int w);
        bus.trigger = 1'b1;
        repeat (w) tick();
        bus.trigger = 1'b0;
    endtask

    task automatic start(input int w, input int d, input int expw, input logic [31:0] s);
        bus.distancia = 9'(d);
        sb.push_back('{s, expw});
        pulse(w);
    endtask

    task automatic wait_state(input logic [3:0] s, input int budget, input string name);
        int n = 0;
        while ((bus.db_estado != s) && (n < budget)) begin
            tick();
            n++;
        end
        if (bus.db_estado != s) begin
            total++;
            bad++;
            $display("FAIL %s timeout: db_estado=%0d required %0d", name, bus.db_estado, s);
        end
    endtask

    task automatic wait_echo(input int budget, input string name);
        int n = 0;
        while (!bus.echo && (n < budget)) begin
            tick();
            n++;
        end
        if (!bus.echo) begin
            total++;
            bad++;
            $display("FAIL %s timeout: echo=%0d required 1", name, bus.echo);
        end
    endtask

    task automatic finish_cycle(input string name);
        wait_state(4'd0, 4000, name);
        repeat (3) tick();
    endtask

    // Stimulus
    initial begin
        int nz;
        reset         = 1'b0;
        bus.trigger   = 1'b0;
        bus.distancia = 9'd0;
        repeat (3) tick();
        check("reset_echo", int'(bus.echo), 0);
        check("reset_ocupado", int'(bus.ocupado), 0);
        check("reset_estado", int'(bus.db_estado), 0);
        reset = 1'b1;
        repeat (2) tick();

        // Nominal measurement
        start(6, 100, 300, SEQ_FULL);
        finish_cycle("t1_end");

        // Minimum-width boundary: 4 rejected, 5 accepted
        start(4, 100, 0, SEQ_REJ);
        finish_cycle("t2_reject_end");
        start(5, 100, 300, SEQ_FULL);
        finish_cycle("t2_accept_end");

        // Distance change during ECO and re-trigger during RAJADA are ignored
        start(6, 100, 300, SEQ_FULL);
        wait_state(4'd2, 40, "t3_rajada");
        pulse(6);
        wait_echo(100, "t3_echo");
        bus.distancia = 9'd7;
        finish_cycle("t3_end");
        repeat (60) tick();
        check("t3_idle_state", int'(bus.db_estado), 0);
        check("t3_idle_echo", int'(bus.echo), 0);

        // Out-of-range and range-edge distances
        start(6, 450, EXP_HI, SEQ_FULL);
        finish_cycle("t4_450_end");
        start(6, 0, EXP_LO, SEQ_FULL);
        finish_cycle("t4_0_end");
        start(6, 401, EXP_HI, SEQ_FULL);
        finish_cycle("t4_401_end");
        start(6, 400, 1200, SEQ_FULL);
        finish_cycle("t4_400_end");
        start(6, 2, 6, SEQ_FULL);
        finish_cycle("t4_2_end");

        // Reset in the middle of the echo, then a fresh full cycle
        bus.distancia = 9'd100;
        pulse(6);
        wait_echo(100, "t5_echo");
        repeat (150) tick();
        mon_flush = 1'b1;
        reset     = 1'b0;
        tick();
        check("t5_rst_echo", int'(bus.echo), 0);
        check("t5_rst_ocupado", int'(bus.ocupado), 0);
        check("t5_rst_estado", int'(bus.db_estado), 0);
        reset = 1'b1;
        repeat (3) tick();
        start(6, 100, 300, SEQ_FULL);
        finish_cycle("t5_end");

        // Trigger held high from FIM into REPOUSO needs a fresh rising edge
        start(6, 20, 60, SEQ_FULL);
        wait_state(4'd4, 200, "t6_fim");
        bus.trigger = 1'b1;
        wait_state(4'd0, 50, "t6_repouso");
        nz = 0;
        repeat (50) begin
            tick();
            if (bus.db_estado != 4'd0) nz++;
        end
        check("t6_held_trigger_ignored", nz, 0);
        bus.trigger = 1'b0;
        repeat (5) tick();
        start(6, 20, 60, SEQ_FULL);
        finish_cycle("t6_end");

        repeat (5) tick();
        check("scoreboard_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
